// File: rtl/qoa_lms_predictor_pkg.sv
// Shared constants and types for the QOA LMS reconstruction stage.
// The format fixes the tap count and prediction shift; neither is tunable here.
package qoa_lms_predictor_pkg;

    localparam int QOA_LMS_TAPS  = 4;
    localparam int QOA_LMS_SHIFT = 13;

    localparam logic signed [15:0] QOA_S16_MAX = 16'sh7FFF;
    localparam logic signed [15:0] QOA_S16_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MAC    = 2'd1,
        ST_UPDATE = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

endpackage

// File: rtl/qoa_lms_predictor_sat16.sv
// Combinational clamp of a 34-bit signed value into the signed 16-bit PCM range.
module qoa_sat16
    import qoa_lms_predictor_pkg::*;
(
    input  logic signed [33:0] i_val,
    output logic signed [15:0] o_sat
);

    localparam logic signed [33:0] SAT_HI = 34'sd32767;
    localparam logic signed [33:0] SAT_LO = -34'sd32768;

    always_comb begin
        o_sat = i_val[15:0];
        if (i_val > SAT_HI) begin
            o_sat = QOA_S16_MAX;
        end else if (i_val < SAT_LO) begin
            o_sat = QOA_S16_MIN;
        end
    end

endmodule

// File: rtl/qoa_lms_predictor.sv
// QOA LMS predictor: serial 4-tap MAC prediction, saturating reconstruction,
// then sign-LMS weight update and history shift, one residual per handshake.
module qoa_lms_predictor
    import qoa_lms_predictor_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lms_load,
    input  logic [1:0]  lms_idx,
    input  logic [15:0] hist_in,
    input  logic [15:0] weight_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] residual,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sample,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // a producer holds valid and data stable until that edge.

    state_t             r_state;
    state_t             w_next_state;
    logic signed [15:0] r_hist [QOA_LMS_TAPS];
    logic signed [15:0] r_w    [QOA_LMS_TAPS];
    logic signed [33:0] r_acc;
    logic [1:0]         r_idx;
    logic signed [15:0] r_res;
    logic signed [15:0] r_sample;
    logic               r_out_valid;

    logic signed [31:0] w_prod;
    logic signed [33:0] w_prod_ext;
    logic signed [33:0] w_pred;
    logic signed [33:0] w_sum;
    logic signed [15:0] w_sat;
    logic signed [15:0] w_delta;
    logic signed [15:0] w_neg_delta;

    assign in_ready  = (r_state == ST_IDLE) && !lms_load;
    assign out_valid = r_out_valid;
    assign sample    = r_sample;
    assign dbg_state = r_state;

    // Single shared multiplier, stepped through the taps by r_idx.
    assign w_prod      = r_hist[r_idx] * r_w[r_idx];
    assign w_prod_ext  = {{2{w_prod[31]}}, w_prod};
    assign w_pred      = r_acc >>> QOA_LMS_SHIFT;
    assign w_sum       = w_pred + {{18{r_res[15]}}, r_res};
    assign w_delta     = r_res >>> 4;
    assign w_neg_delta = -w_delta;

    qoa_sat16 u_sat (
        .i_val (w_sum),
        .o_sat (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid && in_ready) w_next_state = ST_MAC;
            ST_MAC:    if (r_idx == 2'd3) w_next_state = ST_UPDATE;
            ST_UPDATE: w_next_state = ST_OUT;
            ST_OUT:    if (out_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QOA_LMS_TAPS; i++) begin
                r_hist[i] <= '0;
                r_w[i]    <= '0;
            end
            r_acc       <= '0;
            r_idx       <= '0;
            r_res       <= '0;
            r_sample    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lms_load) begin
                        r_hist[lms_idx] <= hist_in;
                        r_w[lms_idx]    <= weight_in;
                    end else if (in_valid) begin
                        r_res <= residual;
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= r_idx + 2'd1;
                end
                ST_UPDATE: begin
                    // Weights adapt against the history as it was before the shift.
                    for (int i = 0; i < QOA_LMS_TAPS; i++) begin
                        r_w[i] <= r_w[i] + (r_hist[i][15] ? w_neg_delta : w_delta);
                    end
                    r_hist[0]   <= r_hist[1];
                    r_hist[1]   <= r_hist[2];
                    r_hist[2]   <= r_hist[3];
                    r_hist[3]   <= w_sat;
                    r_sample    <= w_sat;
                    r_out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qoa_lms_predictor.sv
// Directed and randomized checks of the QOA LMS predictor against an arithmetic model.
module tb_qoa_lms_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lms_load = 1'b0;
  logic [1:0]  lms_idx = '0;
  logic [15:0] hist_in = '0;
  logic [15:0] weight_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] residual = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sample;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int mh[4];
  int mw[4];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  qoa_lms_predictor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lms_load  (lms_load),
    .lms_idx   (lms_idx),
    .hist_in   (hist_in),
    .weight_in (weight_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .residual  (residual),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sample    (sample),
    .dbg_state (dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int wrap16(input int x);
    int y;
    y = x & 32'hFFFF;
    if (y > 32767) y -= 65536;
    return y;
  endfunction

  function automatic int floor_div(input longint num, input longint den);
    if (num >= 0) return int'(num / den);
    return int'(-((-num + den - 1) / den));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mh[i] = 0;
      mw[i] = 0;
    end
    exp_q.delete();
  endtask

  // Prediction, clamp, sign-LMS adaptation and history shift from plain arithmetic.
  task automatic model_step(input int res);
    longint dot;
    int pred, s, d;
    dot = 0;
    for (int i = 0; i < 4; i++) dot += longint'(mh[i]) * longint'(mw[i]);
    pred = floor_div(dot, 8192);
    s = pred + res;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    d = floor_div(longint'(res), 16);
    for (int i = 0; i < 4; i++) mw[i] = wrap16(mw[i] + ((mh[i] < 0) ? -d : d));
    for (int i = 0; i < 3; i++) mh[i] = mh[i + 1];
    mh[3] = s;
    exp_q.push_back(s[15:0]);
  endtask

  task automatic load_tap(input int idx, input int h, input int w);
    @(negedge clk);
    lms_load = 1'b1;
    lms_idx = idx[1:0];
    hist_in = h[15:0];
    weight_in = w[15:0];
    #1 check("load_blocks_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 lms_load = 1'b0;
    mh[idx] = h;
    mw[idx] = w;
  endtask

  task automatic load_state(input int h0, h1, h2, h3, w0, w1, w2, w3);
    load_tap(0, h0, w0);
    load_tap(1, h1, w1);
    load_tap(2, h2, w2);
    load_tap(3, h3, w3);
  endtask

  task automatic accept(input int res);
    @(negedge clk);
    check("idle_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    residual = res[15:0];
    model_step(res);
    @(posedge clk);
    #1 in_valid = 1'b0;
    residual = 16'($urandom);
  endtask

  // Waits for the sample, checks latency and value, holds out_ready low for
  // 'hold' cycles (optionally poking in_valid/lms_load), then completes it.
  task automatic collect(input string tag, input int hold, input bit poke);
    bit early = 1'b0;
    bit unstable = 1'b0;
    int n = 0;
    logic [15:0] exp_s;
    logic [15:0] held;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) early = 1'b1;
    end
    check({tag, "_early"}, int'(early), 0);
    @(negedge clk);
    check({tag, "_latency"}, int'(out_valid), 1);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check({tag, "_sample"}, s16(sample), s16(exp_s));
    held = sample;
    for (int c = 0; c < hold; c++) begin
      if (poke) begin
        in_valid = (c % 3 == 0);
        residual = 16'($urandom);
        lms_load = (c % 4 == 1);
        lms_idx = 2'($urandom_range(0, 3));
        hist_in = 16'($urandom);
        weight_in = 16'($urandom);
      end
      @(negedge clk);
      if (!out_valid || sample !== held || in_ready) unstable = 1'b1;
    end
    in_valid = 1'b0;
    lms_load = 1'b0;
    if (hold > 0) check({tag, "_hold_stable"}, int'(unstable), 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_released"}, int'(out_valid), 0);
  endtask

  initial begin
    model_reset();
    // Reset
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_sample", s16(sample), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);

    // 1: zero state, residual 100
    accept(100);
    collect("t1", 0, 1'b0);
    for (int i = 0; i < 4; i++) check("t1_weight", s16(dut.r_w[i]), 6);
    check("t1_hist3", s16(dut.r_hist[3]), 100);

    // 2: prediction from loaded state
    load_state(0, 0, 0, 1000, 0, 0, -8192, 16384);
    accept(5);
    collect("t2", 0, 1'b0);
    check("t2_w2", s16(dut.r_w[2]), -8192);
    check("t2_hist2", s16(dut.r_hist[2]), 1000);

    // 3: saturation both ways
    load_state(0, 0, 0, 32767, 0, 0, 0, 16384);
    accept(14336);
    collect("t3_pos", 0, 1'b0);
    load_state(0, 0, 0, -32768, 0, 0, 0, 16384);
    accept(-14336);
    collect("t3_neg", 0, 1'b0);

    // 4: floor of negative prediction and negative-history adaptation
    load_state(0, 0, 0, -1, 0, 0, 0, 1);
    accept(-1);
    collect("t4", 0, 1'b0);
    check("t4_w3", s16(dut.r_w[3]), 2);

    // 5: backpressure with ignored in_valid / lms_load pulses
    accept(1234);
    collect("t5", 10, 1'b1);
    @(negedge clk);
    check("t5_back_idle", int'(in_ready), 1);
    accept(-77);
    collect("t5_next", 0, 1'b0);

    // 6: reset during MAC aborts the sample
    load_state(300, -400, 500, -600, 1000, 2000, 3000, 4000);
    accept(321);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_sample", s16(sample), 0);
    check("t6_acc", int'(dut.r_acc), 0);
    check("t6_hist0", s16(dut.r_hist[0]), 0);
    check("t6_w3", s16(dut.r_w[3]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    accept(7);
    collect("t6_after", 0, 1'b0);

    // Randomized run
    for (int k = 0; k < 40; k++) begin
      int r;
      if ($urandom_range(0, 3) == 0) begin
        int h, w;
        h = $urandom_range(0, 65535);
        if (h > 32767) h -= 65536;
        w = int'($urandom_range(0, 40000)) - 20000;
        load_tap($urandom_range(0, 3), h, w);
      end
      r = $urandom_range(0, 65535);
      if (r > 32767) r -= 65536;
      if (k % 3 == 0) r = r / 8;
      accept(r);
      collect("rnd", $urandom_range(0, 3), k[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
